// File: rtl/mul_pkg.sv
// Shared constants for the ECC multiplier scheduler and the Karatsuba recombination.
package mul_pkg;

    localparam int FE_W     = 255;
    localparam int PROD_W   = 510;
    localparam int KS_SPLIT = 128;
    localparam int MUL_LAT  = 3;

    localparam int H0_W = 254;
    localparam int L0_W = 256;
    localparam int M0_W = 258;

    localparam logic REQ_PT  = 1'b0;
    localparam logic REQ_INV = 1'b1;

endpackage

// File: rtl/karatsuba_combine.sv
// Purely combinational recombination of the Karatsuba partial products into X*Y.
module karatsuba_combine
    import mul_pkg::*;
(
    input  logic [H0_W-1:0]   i_h0,
    input  logic [L0_W-1:0]   i_l0,
    input  logic [M0_W-1:0]   i_m0,
    output logic [PROD_W-1:0] o_p
);

    logic [M0_W-1:0] w_mid;

    // Cross term A1*B2 + A2*B1; never negative for products of legal operands
    always_comb begin
        w_mid = i_m0 - {4'd0, i_h0} - {2'd0, i_l0};
        o_p   = {i_h0, 256'd0}
              + {124'd0, w_mid, 128'd0}
              + {254'd0, i_l0};
    end

endmodule

// File: rtl/mul_sched.sv
// Round-robin sharing of the fixed-latency Karatsuba multiplier between the
// point-arithmetic and field-inversion units, with in-order tagged responses.
module mul_sched
    import mul_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [FE_W-1:0]   req0_x,
    input  logic [FE_W-1:0]   req0_y,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [FE_W-1:0]   req1_x,
    input  logic [FE_W-1:0]   req1_y,
    output logic [FE_W-1:0]   mul_x,
    output logic [FE_W-1:0]   mul_y,
    input  logic [H0_W-1:0]   mul_h0,
    input  logic [L0_W-1:0]   mul_l0,
    input  logic [M0_W-1:0]   mul_m0,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [PROD_W-1:0] rsp_p,
    output logic              busy
);

    logic               r_rr_ptr;
    logic [MUL_LAT-1:0] r_trk_v;
    logic [MUL_LAT-1:0] r_trk_id;
    logic               r_rsp_valid;
    logic               r_rsp_id;
    logic [PROD_W-1:0]  r_rsp_p;

    logic               w_gnt0;
    logic               w_gnt1;
    logic               w_issue;
    logic               w_gnt_id;
    logic [PROD_W-1:0]  w_p;
    logic               w_align_v;
    logic               w_align_id;

    // Grant arbitration: single requester wins outright, ties go to rr_ptr
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (req0_valid && req1_valid) begin
            if (r_rr_ptr == REQ_PT) begin
                w_gnt0 = 1'b1;
            end else begin
                w_gnt1 = 1'b1;
            end
        end else if (req0_valid) begin
            w_gnt0 = 1'b1;
        end else if (req1_valid) begin
            w_gnt1 = 1'b1;
        end else begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
        end
        w_issue  = w_gnt0 | w_gnt1;
        w_gnt_id = w_gnt1 ? REQ_INV : REQ_PT;
    end

    // Operand mux; an idle cycle drives zeros so the pipeline does not toggle
    always_comb begin
        mul_x = {FE_W{1'b0}};
        mul_y = {FE_W{1'b0}};
        if (w_gnt0) begin
            mul_x = req0_x;
            mul_y = req0_y;
        end else if (w_gnt1) begin
            mul_x = req1_x;
            mul_y = req1_y;
        end else begin
            mul_x = {FE_W{1'b0}};
            mul_y = {FE_W{1'b0}};
        end
    end

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    // Round-robin pointer favours the requester that lost the last grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= 1'b0;
        end else if (w_issue) begin
            r_rr_ptr <= ~w_gnt_id;
        end else begin
            r_rr_ptr <= r_rr_ptr;
        end
    end

    // Valid/ID shadow of the multiplier pipeline; reset drops in-flight ops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_trk_v  <= {MUL_LAT{1'b0}};
            r_trk_id <= {MUL_LAT{1'b0}};
        end else begin
            r_trk_v  <= {r_trk_v[MUL_LAT-2:0], w_issue};
            r_trk_id <= {r_trk_id[MUL_LAT-2:0], w_gnt_id};
        end
    end

    assign w_align_v  = r_trk_v[MUL_LAT-1];
    assign w_align_id = r_trk_id[MUL_LAT-1];

    karatsuba_combine u_combine (
        .i_h0 (mul_h0),
        .i_l0 (mul_l0),
        .i_m0 (mul_m0),
        .o_p  (w_p)
    );

    // Response register; product and tag hold between pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_p     <= {PROD_W{1'b0}};
        end else if (w_align_v) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= w_align_id;
            r_rsp_p     <= w_p;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= r_rsp_id;
            r_rsp_p     <= r_rsp_p;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_p     = r_rsp_p;
    assign busy      = (|r_trk_v) | r_rsp_valid;

endmodule

// File: tb/tb_mul_sched.sv
// Directed bench for mul_sched with a behavioural 3-stage Karatsuba multiplier.
module tb_mul_sched;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_valid = 1'b0;
    logic         req0_ready;
    logic [254:0] req0_x = '0;
    logic [254:0] req0_y = '0;
    logic         req1_valid = 1'b0;
    logic         req1_ready;
    logic [254:0] req1_x = '0;
    logic [254:0] req1_y = '0;
    logic [254:0] mul_x;
    logic [254:0] mul_y;
    logic [253:0] mul_h0;
    logic [255:0] mul_l0;
    logic [257:0] mul_m0;
    logic         rsp_valid;
    logic         rsp_id;
    logic [509:0] rsp_p;
    logic         busy;

    mul_sched dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_x     (req0_x),
        .req0_y     (req0_y),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_x     (req1_x),
        .req1_y     (req1_y),
        .mul_x      (mul_x),
        .mul_y      (mul_y),
        .mul_h0     (mul_h0),
        .mul_l0     (mul_l0),
        .mul_m0     (mul_m0),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_p      (rsp_p),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [767:0] mul_model(input logic [254:0] x, input logic [254:0] y);
        logic [257:0] a1, a2, b1, b2, h, l, m;
        a1 = {130'd0, x[127:0]};
        a2 = {131'd0, x[254:128]};
        b1 = {130'd0, y[127:0]};
        b2 = {131'd0, y[254:128]};
        h  = a2 * b2;
        l  = a1 * b1;
        m  = (a1 + a2) * (b1 + b2);
        return {h[253:0], l[255:0], m};
    endfunction

    logic [767:0] m_s0, m_s1, m_s2;
    always @(posedge clk) begin
        m_s0 <= mul_model(mul_x, mul_y);
        m_s1 <= m_s0;
        m_s2 <= m_s1;
    end
    assign mul_h0 = m_s2[767:514];
    assign mul_l0 = m_s2[513:258];
    assign mul_m0 = m_s2[257:0];

    typedef struct {
        int           due;
        logic         id;
        logic [509:0] p;
    } exp_t;

    exp_t         exp_q[$];
    int           n_cmp = 0;
    int           n_err = 0;
    int           cyc   = 0;
    logic [509:0] last_p = '0;

    task automatic chk(input string tag, input logic [509:0] obs, input logic [509:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", tag, cyc, obs, expv);
        end
    endtask

    task automatic check_rsp();
        logic popped;
        popped = 1'b0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            chk("rsp_valid", rsp_valid, 1'b1);
            chk("rsp_id", rsp_id, exp_q[0].id);
            chk("rsp_p", rsp_p, exp_q[0].p);
            last_p = exp_q[0].p;
            void'(exp_q.pop_front());
            popped = 1'b1;
        end else begin
            chk("rsp_quiet", rsp_valid, 1'b0);
            chk("rsp_hold", rsp_p, last_p);
        end
        chk("busy", busy, (exp_q.size() > 0) || popped);
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        check_rsp();
    endtask

    // eg: expected grant (-1 none); ep: hand-computed product of the granted pair
    task automatic drive(input logic v0, input logic [254:0] x0, input logic [254:0] y0,
                         input logic v1, input logic [254:0] x1, input logic [254:0] y1,
                         input int eg, input logic [509:0] ep);
        exp_t e;
        req0_valid = v0; req0_x = x0; req0_y = y0;
        req1_valid = v1; req1_x = x1; req1_y = y1;
        #1;
        chk("rdy0", req0_ready, eg == 0);
        chk("rdy1", req1_ready, eg == 1);
        if (eg >= 0) begin
            e.due = cyc + 4;
            e.id  = (eg == 1);
            e.p   = ep;
            exp_q.push_back(e);
        end else begin
            chk("mul_x_idle", mul_x, 510'd0);
            chk("mul_y_idle", mul_y, 510'd0);
        end
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, '0, '0, -1, '0);
    endtask

    logic [254:0] ones;
    logic [254:0] p128;
    logic [254:0] a;
    logic [254:0] b;
    logic [509:0] e_max;
    logic [509:0] e_split;
    logic [509:0] c0_p [3];
    logic [509:0] c1_p [3];

    initial begin
        ones    = {255{1'b1}};
        p128    = 255'd1 << 128;
        e_max   = {{254{1'b1}}, 255'd0, 1'b1};
        e_split = (510'd1 << 255) - (510'd1 << 127);
        c0_p[0] = 510'd200;  c0_p[1] = 510'd231;  c0_p[2] = 510'd264;
        c1_p[0] = 510'd1200; c1_p[1] = 510'd1271; c1_p[2] = 510'd1344;

        // reset state
        #1;
        chk("rst_valid", rsp_valid, 1'b0);
        chk("rst_id", rsp_id, 1'b0);
        chk("rst_p", rsp_p, 510'd0);
        chk("rst_busy", busy, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // contention from reset: grants alternate starting with req0
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 255'(10 + k), 255'(20 + k), 1'b1, 255'(30 + k), 255'(40 + k), 0, c0_p[k]);
            drive(1'b1, 255'(11 + k), 255'(21 + k), 1'b1, 255'(30 + k), 255'(40 + k), 1, c1_p[k]);
        end
        idle(6);

        // single op
        drive(1'b1, 255'd2, 255'd3, 1'b0, '0, '0, 0, 510'd6);
        idle(6);

        // max operands from req1
        drive(1'b0, '0, '0, 1'b1, ones, ones, 1, e_max);
        idle(6);

        // split-boundary carries
        drive(1'b1, p128, p128, 1'b0, '0, '0, 0, 510'd1 << 256);
        a = p128 - 255'd1;
        b = 255'd1 << 127;
        drive(1'b0, '0, '0, 1'b1, a, b, 1, e_split);
        idle(6);

        // streaming: 10 back-to-back req0 issues
        for (int i = 0; i < 10; i++)
            drive(1'b1, 255'(i + 1), 255'(i + 2), 1'b0, '0, '0, 0, 510'((i + 1) * (i + 2)));
        idle(6);

        // reset mid-flight after three req0 issues (leaves rr_ptr pointing at req1)
        drive(1'b1, 255'd3, 255'd4, 1'b0, '0, '0, 0, 510'd12);
        drive(1'b1, 255'd5, 255'd6, 1'b0, '0, '0, 0, 510'd30);
        drive(1'b1, 255'd7, 255'd8, 1'b0, '0, '0, 0, 510'd56);
        req0_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_valid", rsp_valid, 1'b0);
        exp_q.delete();
        last_p = '0;
        tick();
        rst = 1'b0;
        idle(5);
        drive(1'b1, 255'd5, 255'd7, 1'b1, 255'd9, 255'd9, 0, 510'd35);
        drive(1'b0, '0, '0, 1'b1, 255'd9, 255'd9, 1, 510'd81);
        idle(6);

        chk("queue_drained", 510'(exp_q.size()), 510'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
